// File: rtl/puf_hybrid_ctrl_if.sv
// Request/response bundle and per-core enable/valid handshakes of the hybrid PUF controller.
interface puf_hybrid_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       mode;
    logic             ext_sel;
    logic [WIDTH-1:0] challenge_in;
    logic [WIDTH-1:0] challenge;
    logic             arb_enable;
    logic             arb_valid;
    logic [WIDTH-1:0] arb_response;
    logic             ro_enable;
    logic             ro_valid;
    logic [WIDTH-1:0] ro_response;
    logic             busy;
    logic [WIDTH-1:0] response;
    logic [WIDTH-1:0] unstable;
    logic             response_valid;
    logic             error;

    modport slave (
        input  start, mode, ext_sel, challenge_in,
        input  arb_valid, arb_response, ro_valid, ro_response,
        output challenge, arb_enable, ro_enable,
        output busy, response, unstable, response_valid, error
    );

    modport master (
        output start, mode, ext_sel, challenge_in,
        output arb_valid, arb_response, ro_valid, ro_response,
        input  challenge, arb_enable, ro_enable,
        input  busy, response, unstable, response_valid, error
    );
endinterface

// File: rtl/puf_hybrid_ctrl.sv
// Hybrid PUF controller: sequences VOTES evaluations on the arbiter/RO cores,
// majority-votes the samples per bit and flags bits whose votes disagreed.
module puf_hybrid_ctrl #(
    parameter int               WIDTH   = 8,
    parameter int               VOTES   = 5,
    parameter logic [WIDTH-1:0] TAPS    = 8'hB8,
    parameter logic [WIDTH-1:0] SEED    = 8'hA5,
    parameter int               TIMEOUT = 1023
) (
    input  logic             clk_i,
    input  logic             rst_i,
    puf_hybrid_ctrl_if.slave ctrl_if
);

    localparam int               CW       = $clog2(VOTES + 1);
    localparam int               TW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]    VOTES_C  = CW'(VOTES);
    localparam logic [CW-1:0]    HALF_C   = CW'(VOTES / 2);
    localparam logic [TW-1:0]    TLAST_C  = TW'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_EVAL   = 3'd2,
        S_GAP    = 3'd3,
        S_DECIDE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] cur);
        return {cur[WIDTH-2:0], ^(cur & TAPS)};
    endfunction

    state_t           state_q;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] challenge_q;
    logic             arb_en_q;
    logic             ro_en_q;
    logic             arb_got_q;
    logic             ro_got_q;
    logic [WIDTH-1:0] arb_resp_q;
    logic [WIDTH-1:0] ro_resp_q;
    logic [CW-1:0]    ones_q [WIDTH];
    logic [CW-1:0]    vote_q;
    logic [TW-1:0]    tcnt_q;
    logic             busy_q;
    logic [WIDTH-1:0] response_q;
    logic [WIDTH-1:0] unstable_q;
    logic             rvalid_q;
    logic             error_q;

    logic             arb_need_s;
    logic             ro_need_s;
    logic             all_s;
    logic [WIDTH-1:0] arb_val_s;
    logic [WIDTH-1:0] ro_val_s;
    logic [WIDTH-1:0] sample_s;

    // Which cores the latched mode needs, and the sample once all of them have answered.
    always_comb begin
        arb_need_s = 1'b0;
        ro_need_s  = 1'b0;
        sample_s   = '0;
        arb_val_s  = arb_got_q ? arb_resp_q : ctrl_if.arb_response;
        ro_val_s   = ro_got_q ? ro_resp_q : ctrl_if.ro_response;
        case (mode_q)
            2'b00: begin
                arb_need_s = 1'b1;
                sample_s   = arb_val_s;
            end
            2'b01: begin
                ro_need_s = 1'b1;
                sample_s  = ro_val_s;
            end
            2'b10: begin
                arb_need_s = 1'b1;
                ro_need_s  = 1'b1;
                sample_s   = arb_val_s ^ ro_val_s;
            end
            default: begin
                arb_need_s = 1'b0;
                ro_need_s  = 1'b0;
                sample_s   = '0;
            end
        endcase
        all_s = (~arb_need_s | arb_got_q | ctrl_if.arb_valid) &
                (~ro_need_s | ro_got_q | ctrl_if.ro_valid);
    end

    // Controller FSM; every output is a register so enables and strobes are glitch-free.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            mode_q      <= 2'b00;
            lfsr_q      <= SEED_EFF;
            challenge_q <= '0;
            arb_en_q    <= 1'b0;
            ro_en_q     <= 1'b0;
            arb_got_q   <= 1'b0;
            ro_got_q    <= 1'b0;
            arb_resp_q  <= '0;
            ro_resp_q   <= '0;
            for (int i = 0; i < WIDTH; i++) ones_q[i] <= '0;
            vote_q      <= '0;
            tcnt_q      <= '0;
            busy_q      <= 1'b0;
            response_q  <= '0;
            unstable_q  <= '0;
            rvalid_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            error_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Mode and challenge source are captured here so later input changes cannot leak in.
                    if (ctrl_if.start) begin
                        if (ctrl_if.mode == 2'b11) begin
                            error_q <= 1'b1;
                        end else begin
                            mode_q  <= ctrl_if.mode;
                            busy_q  <= 1'b1;
                            state_q <= S_LOAD;
                            if (ctrl_if.ext_sel) begin
                                challenge_q <= ctrl_if.challenge_in;
                            end else begin
                                challenge_q <= lfsr_q;
                                lfsr_q      <= lfsr_step(lfsr_q);
                            end
                        end
                    end
                end
                S_LOAD: begin
                    for (int i = 0; i < WIDTH; i++) ones_q[i] <= '0;
                    vote_q    <= '0;
                    tcnt_q    <= '0;
                    arb_got_q <= 1'b0;
                    ro_got_q  <= 1'b0;
                    arb_en_q  <= arb_need_s;
                    ro_en_q   <= ro_need_s;
                    state_q   <= S_EVAL;
                end
                S_EVAL: begin
                    if (all_s) begin
                        for (int i = 0; i < WIDTH; i++) ones_q[i] <= ones_q[i] + CW'(sample_s[i]);
                        vote_q   <= vote_q + CW'(1);
                        arb_en_q <= 1'b0;
                        ro_en_q  <= 1'b0;
                        state_q  <= S_GAP;
                    end else if (tcnt_q == TLAST_C) begin
                        error_q  <= 1'b1;
                        arb_en_q <= 1'b0;
                        ro_en_q  <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                        if (ctrl_if.arb_valid && !arb_got_q) begin
                            arb_got_q  <= 1'b1;
                            arb_resp_q <= ctrl_if.arb_response;
                        end
                        if (ctrl_if.ro_valid && !ro_got_q) begin
                            ro_got_q  <= 1'b1;
                            ro_resp_q <= ctrl_if.ro_response;
                        end
                    end
                end
                S_GAP: begin
                    tcnt_q    <= '0;
                    arb_got_q <= 1'b0;
                    ro_got_q  <= 1'b0;
                    if (vote_q < VOTES_C) begin
                        arb_en_q <= arb_need_s;
                        ro_en_q  <= ro_need_s;
                        state_q  <= S_EVAL;
                    end else begin
                        state_q <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        response_q[i] <= (ones_q[i] > HALF_C);
                        unstable_q[i] <= (ones_q[i] != '0) && (ones_q[i] != VOTES_C);
                    end
                    rvalid_q <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    arb_en_q <= 1'b0;
                    ro_en_q  <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign ctrl_if.challenge      = challenge_q;
    assign ctrl_if.arb_enable     = arb_en_q;
    assign ctrl_if.ro_enable      = ro_en_q;
    assign ctrl_if.busy           = busy_q;
    assign ctrl_if.response       = response_q;
    assign ctrl_if.unstable       = unstable_q;
    assign ctrl_if.response_valid = rvalid_q;
    assign ctrl_if.error          = error_q;

endmodule

// File: tb/tb_puf_hybrid_ctrl.sv
// Scoreboard bench for puf_hybrid_ctrl: behavioural core models, majority-vote
// reference model, decoupled monitor comparing every Response_Valid / Error strobe.
module tb_puf_hybrid_ctrl;

    localparam int         W       = 8;
    localparam int         VOTES   = 5;
    localparam int         TIMEOUT = 1023;
    localparam logic [7:0] TAPS    = 8'hB8;
    localparam logic [7:0] SEED    = 8'hA5;

    typedef struct {
        bit          is_err;
        logic [7:0]  chal;
        logic [7:0]  resp;
        logic [7:0]  unst;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [1:0]  exp_en = 2'b00;

    logic [7:0]  m_lfsr = SEED;
    logic [7:0]  m_chal = 8'h00;

    logic [7:0]  arb_tab [VOTES];
    logic [7:0]  ro_tab  [VOTES];
    int          arb_dly [VOTES];
    int          ro_dly  [VOTES];
    bit          never_valid = 1'b0;
    int          arb_idx = 0, arb_cnt = 0;
    int          ro_idx = 0, ro_cnt = 0;

    puf_hybrid_ctrl_if #(.WIDTH(W)) bus ();

    puf_hybrid_ctrl #(
        .WIDTH(W), .VOTES(VOTES), .TAPS(TAPS), .SEED(SEED), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .ctrl_if(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        int p;
        p = $countones(s & TAPS) % 2;
        return 8'((s << 1) | 8'(p));
    endfunction

    // Arbiter core model: valid appears arb_dly cycles after enable rises.
    always @(negedge clk) begin
        if (!bus.busy) begin
            arb_idx = 0; arb_cnt = 0; bus.arb_valid = 1'b0;
        end else if (bus.arb_enable) begin
            arb_cnt++;
            bus.arb_response = arb_tab[arb_idx % VOTES];
            bus.arb_valid    = !never_valid && (arb_cnt > arb_dly[arb_idx % VOTES]);
        end else begin
            if (arb_cnt > 0) arb_idx++;
            arb_cnt = 0; bus.arb_valid = 1'b0;
        end
    end

    // RO core model, same behaviour with its own table.
    always @(negedge clk) begin
        if (!bus.busy) begin
            ro_idx = 0; ro_cnt = 0; bus.ro_valid = 1'b0;
        end else if (bus.ro_enable) begin
            ro_cnt++;
            bus.ro_response = ro_tab[ro_idx % VOTES];
            bus.ro_valid    = !never_valid && (ro_cnt > ro_dly[ro_idx % VOTES]);
        end else begin
            if (ro_cnt > 0) ro_idx++;
            ro_cnt = 0; bus.ro_valid = 1'b0;
        end
    end

    // Monitor: pops one expectation per output strobe; also watches the enable pattern.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.response_valid || bus.error) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_strobe: rv=%0b err=%0b with empty scoreboard", bus.response_valid, bus.error);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("strobe_kind", {bus.response_valid, bus.error}, mon_e.is_err ? 2'b01 : 2'b10);
                    check("strobe_cycle", cyc, mon_e.due);
                    check("challenge", bus.challenge, mon_e.chal);
                    if (!mon_e.is_err) begin
                        check("response", bus.response, mon_e.resp);
                        check("unstable", bus.unstable, mon_e.unst);
                    end
                end
            end
            if (bus.busy && (bus.arb_enable || bus.ro_enable))
                check("enable_pattern", {bus.arb_enable, bus.ro_enable}, exp_en);
        end
    end

    task automatic fill(input logic [7:0] a, input logic [7:0] r, input int da, input int dr);
        for (int v = 0; v < VOTES; v++) begin
            arb_tab[v] = a; ro_tab[v] = r; arb_dly[v] = da; ro_dly[v] = dr;
        end
    endtask

    task automatic run_txn(input int md, input bit ext, input logic [7:0] cin,
                           input bit never, input int reset_at);
        exp_t        e;
        int          sum, d, g;
        int          ones [8];
        logic [7:0]  s;
        int unsigned issue;
        g = 0;
        while (bus.busy && g < 3000) begin @(negedge clk); g++; end
        never_valid = never;
        @(negedge clk);
        e.is_err = 1'b0; e.resp = 8'h00; e.unst = 8'h00; e.chal = m_chal;
        sum = 0;
        for (int b = 0; b < 8; b++) ones[b] = 0;
        if (md == 3) begin
            e.is_err = 1'b1; e.due = cyc + 1;
        end else begin
            if (ext) m_chal = cin;
            else begin m_chal = m_lfsr; m_lfsr = lfsr_next(m_lfsr); end
            e.chal = m_chal;
            if (never) begin
                e.is_err = 1'b1; e.due = cyc + 2 + TIMEOUT;
            end else begin
                for (int v = 0; v < VOTES; v++) begin
                    if (md == 0) begin s = arb_tab[v]; d = arb_dly[v]; end
                    else if (md == 1) begin s = ro_tab[v]; d = ro_dly[v]; end
                    else begin
                        s = arb_tab[v] ^ ro_tab[v];
                        d = (arb_dly[v] > ro_dly[v]) ? arb_dly[v] : ro_dly[v];
                    end
                    sum += d + 2;
                    for (int b = 0; b < 8; b++) ones[b] += int'(s[b]);
                end
                for (int b = 0; b < 8; b++) begin
                    e.resp[b] = (ones[b] > VOTES / 2);
                    e.unst[b] = (ones[b] != 0) && (ones[b] != VOTES);
                end
                e.due = cyc + 3 + sum;
            end
        end
        if (reset_at == 0) sb_q.push_back(e);
        exp_en = (md == 0) ? 2'b10 : (md == 1) ? 2'b01 : 2'b11;
        issue = cyc;
        bus.start = 1'b1; bus.mode = 2'(md); bus.ext_sel = ext; bus.challenge_in = cin;
        @(negedge clk);
        bus.start = 1'b0;
        g = 0;
        while (bus.busy && g < 3000) begin
            if (reset_at != 0 && cyc == issue + reset_at) begin
                bus.start = 1'b0;
                rst = 1'b1;
                #1;
                check("outputs_in_reset",
                      {bus.challenge, bus.response, bus.unstable, bus.busy, bus.arb_enable,
                       bus.ro_enable, bus.response_valid, bus.error}, 32'h0);
                m_lfsr = SEED; m_chal = 8'h00;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                bus.start        = 1'($urandom_range(0, 1));
                bus.mode         = 2'($urandom);
                bus.ext_sel      = 1'($urandom);
                bus.challenge_in = 8'($urandom);
                @(negedge clk);
                g++;
            end
        end
        bus.start = 1'b0;
        if (g >= 3000) begin
            n_cmp++; n_bad++;
            $display("FAIL busy_timeout: busy still %0b after %0d cycles", bus.busy, g);
        end
    endtask

    initial begin
        logic [7:0] base;
        int         md;
        bus.start = 1'b0; bus.mode = 2'b00; bus.ext_sel = 1'b0; bus.challenge_in = 8'h00;
        bus.arb_valid = 1'b0; bus.arb_response = 8'h00; bus.ro_valid = 1'b0; bus.ro_response = 8'h00;
        fill(8'h00, 8'h00, 1, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_state",
              {bus.challenge, bus.response, bus.unstable, bus.busy, bus.arb_enable,
               bus.ro_enable, bus.response_valid, bus.error}, 32'h0);

        fill(8'h3C, 8'h00, 1, 1);
        run_txn(0, 1'b0, 8'h00, 1'b0, 0);
        fill(8'h00, 8'hF0, 1, 1);
        ro_tab[3] = 8'h0F; ro_tab[4] = 8'h0F;
        run_txn(1, 1'b0, 8'h00, 1'b0, 0);
        fill(8'hAA, 8'h0F, 1, 4);
        run_txn(2, 1'b0, 8'h00, 1'b0, 0);
        fill(8'h00, 8'h00, 1, 1);
        run_txn(0, 1'b0, 8'h00, 1'b1, 0);
        run_txn(3, 1'b0, 8'h00, 1'b0, 0);
        fill(8'h96, 8'h00, 1, 1);
        run_txn(0, 1'b1, 8'h5A, 1'b0, 0);
        run_txn(0, 1'b0, 8'h00, 1'b0, 8);
        run_txn(0, 1'b0, 8'h00, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            md   = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            base = 8'($urandom);
            for (int v = 0; v < VOTES; v++) begin
                arb_tab[v] = base ^ (($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00);
                ro_tab[v]  = 8'($urandom);
                arb_dly[v] = int'($urandom_range(0, 5));
                ro_dly[v]  = int'($urandom_range(0, 5));
            end
            run_txn(md, 1'($urandom), 8'($urandom), 1'b0, 0);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/puf_hybrid_ctrl.md
Name: puf_hybrid_ctrl

Overview:
Parametrised controller for the hybrid PUF. It generates or accepts a challenge and sequences evaluations on the external arbiter and ring-oscillator PUF cores using per-core enable/valid handshakes. It adds an XOR mode, majority voting over VOTES evaluations, an instability mask and a timeout error. It sits between the system-level request logic and the two PUF cores, and replaces the fixed 8-bit clock-gated selection scheme.

Parameters:
WIDTH, 8, challenge/response width in bits (>= 2)
VOTES, 5, evaluations per request; odd, 1..15
TAPS, 8'hB8, Fibonacci LFSR feedback mask (bit i set = tap on bit i), WIDTH bits
SEED, 8'hA5, LFSR reset value, WIDTH bits; an all-zero SEED is replaced by 1
TIMEOUT, 1023, max cycles to wait for the core valid(s) per evaluation

Ports:
Clock  in  1  single system clock, rising edge
Reset  in  1  asynchronous, active-high; clears all state
Start  in  1  request; sampled only in IDLE
Mode  in  2  00 arbiter, 01 RO, 10 arbiter XOR RO, 11 reserved
Ext_Sel  in  1  1 = use Challenge_In, 0 = use internal LFSR
Challenge_In  in  WIDTH  external challenge
Challenge  out  WIDTH  challenge driven to both cores, stable while Busy
Arb_Enable  out  1  arbiter core evaluate request
Arb_Valid  in  1  arbiter core response strobe
Arb_Response  in  WIDTH  arbiter core response
Ro_Enable  out  1  RO core evaluate request
Ro_Valid  in  1  RO core response strobe
Ro_Response  in  WIDTH  RO core response
Busy  out  1  high from LOAD through DONE
Response  out  WIDTH  majority-voted response
Unstable  out  WIDTH  bit set = votes for that bit were not unanimous
Response_Valid  out  1  one-cycle pulse when Response/Unstable update
Error  out  1  one-cycle pulse on timeout or reserved mode

Behaviour:
- Reset: all outputs 0; LFSR = SEED (or 1 if SEED == 0); counters 0; state IDLE.
- FSM states: IDLE, LOAD, EVAL, GAP, DECIDE, DONE.
- IDLE: Start=1 -> LOAD. If Mode=11 when Start=1: Error pulses the next cycle, state stays IDLE, the LFSR does not advance.
- LOAD (1 cycle): latch Mode. Challenge <= Challenge_In if Ext_Sel=1; otherwise Challenge <= current LFSR value, and the LFSR steps once (new bit0 = XOR-reduce(lfsr & TAPS), shift left). Clear the vote counter, per-bit ones counters and timeout counter. -> EVAL.
- EVAL: drive the enable(s) required by Mode (both in mode 10) high for the whole state. Valids may arrive on different cycles; each core's response is latched on its first valid, and later valids in the same evaluation are ignored. When all required responses are captured:
  - sample = arb, ro, or arb^ro per Mode;
  - ones[i] += sample[i];
  - vote count += 1;
  - -> GAP.
- Timeout in EVAL: the timeout counter increments each cycle in EVAL. When it reaches TIMEOUT -> Error pulse, enables drop, Response unchanged, Response_Valid not asserted, -> IDLE.
- GAP (1 cycle): enables low and timeout counter cleared. Then -> EVAL if vote count < VOTES, else -> DECIDE.
- DECIDE (1 cycle):
  - Response[i] <= (ones[i] > VOTES/2);
  - Unstable[i] <= (ones[i] != 0 && ones[i] != VOTES);
  - -> DONE.
- DONE (1 cycle): Response_Valid = 1, then -> IDLE. Response and Unstable hold until the next DECIDE.
- Ones counters are $clog2(VOTES+1) bits wide and cannot overflow.
- Minimum latency with cores that return valid in the cycle after enable rises: Start to Response_Valid = 2 + 3*VOTES + 1 cycles.
- Busy is high in LOAD, EVAL, GAP, DECIDE and DONE.
- Start while Busy is ignored and is not queued.
- Mode and Ext_Sel changes while Busy have no effect.
- Reset mid-operation: immediate return to the reset state; enables drop asynchronously.
- The LFSR wraps through its full sequence; for maximal-length TAPS the period is 2^WIDTH-1, and the state never becomes zero.

Test Plan:
- Reset, then Start, Mode=00, Ext_Sel=0, arbiter model returns 8'h3C every evaluation -> Challenge=8'hA5, Response=8'h3C, Unstable=0, Response_Valid pulses once at cycle 18; LFSR has stepped once.
- Mode=01, VOTES=5, RO model returns 8'hF0 three times and 8'h0F twice -> Response=8'hF0, Unstable=8'hFF.
- Mode=10, arbiter valid 1 cycle after enable, RO valid 4 cycles after enable, responses 8'hAA and 8'h0F -> Response=8'hA5; each enable stays high until both valids are seen.
- Mode=00 with core never asserting Arb_Valid, TIMEOUT=1023 -> Error pulses once after 1023 EVAL cycles, Response_Valid never asserts, Busy returns to 0.
- Mode=11 Start -> Error pulse, Busy stays 0, Challenge unchanged. Then Ext_Sel=1, Challenge_In=8'h5A -> Challenge=8'h5A.
- Reset asserted during the third EVAL -> all outputs 0 within the same cycle. A following Start produces Challenge=8'hA5 again.
